fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_stage_if_id.sv | 48 ++++
 rtl/fetch_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM state encoding and the bubble instruction.
`default_nettype none

package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: hold beats flush, flush beats load, otherwise a bubble enters.
`default_nettype none

module if_id_regfile #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_hold,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_instr,
  input  logic [WIDTH-1:0] i_pcplus4,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pcplus4,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pcplus4;
  logic             r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr   <= NOP_INSTR;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (!i_hold) begin
      if (i_load && !i_flush) begin
        r_instr   <= i_instr;
        r_pcplus4 <= i_pcplus4;
        r_valid   <= 1'b1;
      end else begin
        r_instr   <= NOP_INSTR;
        r_pcplus4 <= '0;
        r_valid   <= 1'b0;
      end
    end
  end

  assign o_instr   = r_instr;
  assign o_pcplus4 = r_pcplus4;
  assign o_valid   = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, a one-entry skid buffer for decode
// stalls, and redirect handling that discards stale returns.
`default_nettype none

module fetch_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(mips_pkg::NOP_INSTR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic             stall_D,
  input  logic             pcsrc_D,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pcplus4_F,
  output logic             fetch_stall,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] pcplus4_D,
  output logic             valid_D
);

  import mips_pkg::*;

  fetch_state_t     r_state;
  logic             r_kill;
  logic             r_imem_req;
  logic [WIDTH-1:0] r_addr_q;
  logic [WIDTH-1:0] r_buf_q;

  logic             w_redirect;
  logic             w_ack_live;
  logic             w_load;
  logic [WIDTH-1:0] w_pc_aligned;
  logic [WIDTH-1:0] w_load_instr;
  logic [WIDTH-1:0] w_load_pcplus4;

  assign w_pc_aligned   = {pc[WIDTH-1:2], 2'b00};
  assign w_redirect     = pcsrc_D & ~stall_D;
  assign w_ack_live     = (r_state == REQ) & imem_ack & ~r_kill;
  assign w_load         = (w_ack_live | (r_state == HOLD)) & ~stall_D;
  assign w_load_instr   = (r_state == HOLD) ? r_buf_q : imem_rdata;
  assign w_load_pcplus4 = r_addr_q + WIDTH'(4);

  assign pcplus4_F   = pc + WIDTH'(4);
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_addr_q;
  // Only a live (unkilled) return in REQ lets the PC advance.
  assign fetch_stall = ~w_ack_live;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_kill     <= 1'b0;
      r_imem_req <= 1'b0;
      r_addr_q   <= '0;
      r_buf_q    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_imem_req <= 1'b1;
          r_addr_q   <= w_pc_aligned;
        end
        REQ: begin
          if (imem_ack) begin
            if (r_kill) begin
              r_kill   <= 1'b0;
              r_addr_q <= w_pc_aligned;
            end else if (stall_D) begin
              r_buf_q    <= imem_rdata;
              r_state    <= HOLD;
              r_imem_req <= 1'b0;
            end else begin
              r_addr_q <= w_pc_aligned;
            end
          end else if (w_redirect) begin
            r_kill <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall_D) begin
            r_state    <= REQ;
            r_imem_req <= 1'b1;
            r_addr_q   <= w_pc_aligned;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  if_id_regfile #(
    .WIDTH     (WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .i_hold    (stall_D),
    .i_flush   (w_redirect),
    .i_load    (w_load),
    .i_instr   (w_load_instr),
    .i_pcplus4 (w_load_pcplus4),
    .o_instr   (instr_D),
    .o_pcplus4 (pcplus4_D),
    .o_valid   (valid_D)
  );

endmodule

`default_nettype wire
